// File: rtl/edac_pkg.sv
// Shared EDAC definitions: codeword layout, CRC-8 helper, single-bit syndrome
// table generator and the scrubber state encoding.
package edac_pkg;

  localparam logic [7:0] CRC_POLY_DEFAULT = 8'h97;
  localparam int         DATA_W           = 24;
  localparam int         CRC_W            = 8;
  localparam int         CW_W             = DATA_W + CRC_W;
  localparam int         IDX_W            = $clog2(CW_W);
  localparam int         CNT_W            = 16;

  localparam logic [CW_W-1:0] CW_ONE = 32'd1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD_REQ = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_WR_REQ = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // MSB-first CRC-8, zero initial value, no reflection or final xor.
  function automatic logic [CRC_W-1:0] crc8(input logic [DATA_W-1:0] data,
                                            input logic [CRC_W-1:0]  poly);
    logic [CRC_W-1:0] crc;
    logic             fb;
    crc = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb  = crc[CRC_W-1] ^ data[i];
      crc = {crc[CRC_W-2:0], 1'b0};
      if (fb) crc = crc ^ poly;
    end
    return crc;
  endfunction

  // Syndrome produced by a lone flipped bit at each codeword position; entry i
  // sits at bits [i*CRC_W +: CRC_W]. Evaluated at elaboration time.
  function automatic logic [CW_W*CRC_W-1:0] syn_table(input logic [CRC_W-1:0] poly);
    logic [CW_W*CRC_W-1:0] tab;
    logic [CW_W-1:0]       cw;
    tab = '0;
    for (int i = 0; i < CW_W; i++) begin
      cw = CW_ONE << i;
      tab[i*CRC_W +: CRC_W] = crc8(cw[CW_W-1:CRC_W], poly) ^ cw[CRC_W-1:0];
    end
    return tab;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/edac_syndrome_check.sv
// Combinational codeword checker: syndrome, single-bit match, and the
// re-encoded corrected codeword.
module edac_syndrome_check
  import edac_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC_POLY_DEFAULT
) (
  input  logic [CW_W-1:0]  codeword,
  output logic [CRC_W-1:0] syndrome,
  output logic             correctable,
  output logic [IDX_W-1:0] bit_idx,
  output logic [CW_W-1:0]  corrected
);

  localparam logic [CW_W*CRC_W-1:0] SYN_TAB = syn_table(POLY);

  logic [CW_W-1:0] fixed;

  // Match the syndrome against every single-bit pattern, then flip and re-encode.
  always_comb begin
    syndrome    = crc8(codeword[CW_W-1:CRC_W], POLY) ^ codeword[CRC_W-1:0];
    correctable = 1'b0;
    bit_idx     = '0;
    for (int i = 0; i < CW_W; i++) begin
      if (syndrome != '0 && syndrome == SYN_TAB[i*CRC_W +: CRC_W]) begin
        correctable = 1'b1;
        bit_idx     = IDX_W'(i);
      end
    end
    fixed     = codeword ^ (CW_ONE << bit_idx);
    corrected = {fixed[CW_W-1:CRC_W], crc8(fixed[CW_W-1:CRC_W], POLY)};
  end

endmodule

// File: rtl/edac_scrubber.sv
// Background EDAC scrubber: walks FIRST_ADDR..LAST_ADDR, writes back
// single-bit-corrected words and logs uncorrectable ones.
//
// state  | meaning
// IDLE   | waiting for start
// RD_REQ | first cycle after start samples abort; then read held until ack
// CHECK  | classify captured word: clean / correctable / uncorrectable
// WR_REQ | write-back of corrected word held until ack
// NEXT   | stop on last address or abort, else advance
// DONE   | one-cycle done pulse
module edac_scrubber
  import edac_pkg::*;
#(
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] FIRST_ADDR = '0,
  parameter logic [ADDR_W-1:0] LAST_ADDR  = '1,
  parameter logic [CRC_W-1:0]  CRC_POLY   = CRC_POLY_DEFAULT
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CW_W-1:0]   mem_wdata,
  input  logic [CW_W-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic              err_flag
);

  logic [2:0]        state_q,      state_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [CW_W-1:0]   rdata_q,      rdata_d;
  logic              mem_req_q,    mem_req_d;
  logic              mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [CW_W-1:0]   mem_wdata_q,  mem_wdata_d;
  logic [CNT_W-1:0]  corr_cnt_q,   corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;
  logic [ADDR_W-1:0] err_addr_q,   err_addr_d;
  logic              err_flag_q,   err_flag_d;

  logic [CRC_W-1:0]  chk_syndrome;
  logic              chk_correctable;
  logic [IDX_W-1:0]  chk_bit_idx;
  logic [CW_W-1:0]   chk_corrected;

  edac_syndrome_check #(
    .POLY (CRC_POLY)
  ) u_check (
    .codeword    (rdata_q),
    .syndrome    (chk_syndrome),
    .correctable (chk_correctable),
    .bit_idx     (chk_bit_idx),
    .corrected   (chk_corrected)
  );

  // The corrected word already carries the fix, so the bit position is not needed here.
  logic unused_chk;
  assign unused_chk = ^chk_bit_idx;

  // Next-state and handshake register updates; request lines only move on entry or ack.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rdata_d      = rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    err_addr_d   = err_addr_q;
    err_flag_d   = err_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          corr_cnt_d   = '0;
          uncorr_cnt_d = '0;
          err_flag_d   = 1'b0;
          addr_d       = FIRST_ADDR;
          state_d      = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (!mem_req_q) begin
          // Only reached straight after start: abort may still cancel the pass.
          if (abort) begin
            state_d = ST_DONE;
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = addr_q;
          end
        end else if (mem_ack) begin
          rdata_d   = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (chk_syndrome == '0) begin
          state_d = ST_NEXT;
        end else if (chk_correctable) begin
          corr_cnt_d  = sat_inc(corr_cnt_q);
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_wdata_d = chk_corrected;
          state_d     = ST_WR_REQ;
        end else begin
          uncorr_cnt_d = sat_inc(uncorr_cnt_q);
          err_addr_d   = addr_q;
          err_flag_d   = 1'b1;
          state_d      = ST_NEXT;
        end
      end
      ST_WR_REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (addr_q == LAST_ADDR || abort) begin
          state_d = ST_DONE;
        end else begin
          addr_d     = addr_q + 1'b1;
          mem_addr_d = addr_q + 1'b1;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          state_d    = ST_RD_REQ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset returns to IDLE with every output cleared.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= FIRST_ADDR;
      rdata_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
      err_addr_q   <= '0;
      err_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      err_addr_q   <= err_addr_d;
      err_flag_q   <= err_flag_d;
    end
  end

  assign busy       = (state_q == ST_RD_REQ) || (state_q == ST_CHECK) ||
                      (state_q == ST_WR_REQ) || (state_q == ST_NEXT);
  assign done       = (state_q == ST_DONE);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
  assign err_addr   = err_addr_q;
  assign err_flag   = err_flag_q;

endmodule

// File: tb/tb_edac_scrubber.sv
// Directed bench for edac_scrubber on an 8-word memory with a
// variable-latency ack responder.
module tb_edac_scrubber;

  localparam int AW = 3;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, mem_req, mem_we, err_flag;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] mem_addr, err_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic [15:0]   corr_cnt, uncorr_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0]   mem [0:7];
  int            max_delay = 0;
  int            n_reads, n_writes, stab_err, done_seen, done_busy;
  logic [7:0]    read_mask;
  logic [AW-1:0] first_rd, last_wr_addr;
  logic [31:0]   last_wr_data;

  bit            pending;
  int            wcnt;
  logic [AW-1:0] rec_addr;
  logic          rec_we;
  logic [31:0]   rec_wdata;

  edac_scrubber #(
    .ADDR_W     (AW),
    .FIRST_ADDR (3'd0),
    .LAST_ADDR  (3'd7),
    .CRC_POLY   (8'h97)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt),
    .err_addr   (err_addr),
    .err_flag   (err_flag)
  );

  initial forever #5 CLK = ~CLK;

  // Memory responder: ack after 1+delay cycles, checks request stability.
  initial begin
    pending = 0;
    wcnt    = 0;
    forever begin
      @(posedge CLK); #1;
      if (reset) begin
        mem_ack = 1'b0;
        pending = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (!pending) begin
          pending   = 1;
          wcnt      = int'($urandom_range(max_delay, 0));
          rec_addr  = mem_addr;
          rec_we    = mem_we;
          rec_wdata = mem_wdata;
        end else begin
          if (mem_addr !== rec_addr || mem_we !== rec_we || mem_wdata !== rec_wdata) stab_err++;
          if (wcnt == 0) begin
            mem_ack = 1'b1;
            pending = 0;
            if (rec_we) begin
              mem[rec_addr] = rec_wdata;
              n_writes++;
              last_wr_addr = rec_addr;
              last_wr_data = rec_wdata;
            end else begin
              mem_rdata = mem[rec_addr];
              if (n_reads == 0) first_rd = rec_addr;
              n_reads++;
              read_mask[rec_addr] = 1'b1;
            end
          end else begin
            wcnt--;
          end
        end
      end
    end
  end

  // done pulse monitor
  initial forever begin
    @(negedge CLK);
    if (done) begin
      done_seen++;
      if (busy) done_busy++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Remainder of cw(x) modulo x^8+x^7+x^4+x^2+x+1, i.e. the syndrome of cw.
  function automatic logic [7:0] mod_p(input logic [31:0] cw);
    logic [31:0] r;
    logic [31:0] p;
    r = cw;
    p = 32'h197;
    for (int b = 31; b >= 8; b--) if (r[b]) r = r ^ (p << (b - 8));
    return r[7:0];
  endfunction

  task automatic clear_log();
    n_reads = 0; n_writes = 0; stab_err = 0; done_seen = 0; done_busy = 0;
    read_mask = 8'h00; first_rd = '1; last_wr_addr = '0; last_wr_data = 32'hFFFFFFFF;
  endtask

  task automatic mem_zero();
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
  endtask

  task automatic do_start(output logic busy_seen);
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    busy_seen = busy;
  endtask

  task automatic wait_done(output bit got);
    got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (done) begin
        got = 1;
        break;
      end
    end
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    total++; if ({busy, done, mem_req, mem_we} !== 4'b0000) begin bad++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, mem_req, mem_we}); end
    total++; if (mem_addr !== 3'd0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem: addr=%h wdata=%h want 0", mem_addr, mem_wdata); end
    total++; if (corr_cnt !== 16'h0 || uncorr_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt: corr=%h uncorr=%h want 0", corr_cnt, uncorr_cnt); end
    total++; if (err_addr !== 3'd0 || err_flag !== 1'b0) begin bad++; $display("FAIL reset_err: addr=%h flag=%b want 0", err_addr, err_flag); end
    @(posedge CLK); #2 reset = 1'b0;
    repeat (3) @(negedge CLK);
    total++; if ({busy, mem_req} !== 2'b00) begin bad++; $display("FAIL idle_after_reset: busy/req=%b want 00", {busy, mem_req}); end
  endtask

  task automatic test_clean();
    logic b; bit got;
    mem_zero(); clear_log(); max_delay = 0;
    do_start(b);
    wait_done(got);
    total++; if (b !== 1'b1) begin bad++; $display("FAIL clean_busy: got %b want 1", b); end
    total++; if (!got || done_seen != 1) begin bad++; $display("FAIL clean_done: got=%0d pulses=%0d want 1", got, done_seen); end
    total++; if (n_reads != 8 || read_mask !== 8'hFF) begin bad++; $display("FAIL clean_reads: n=%0d mask=%h want 8 ff", n_reads, read_mask); end
    total++; if (n_writes != 0) begin bad++; $display("FAIL clean_writes: got %0d want 0", n_writes); end
    total++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin bad++; $display("FAIL clean_cnt: corr=%0d uncorr=%0d want 0 0", corr_cnt, uncorr_cnt); end
    total++; if (done_busy != 0 || busy !== 1'b0) begin bad++; $display("FAIL clean_busy_end: overlap=%0d busy=%b want 0 0", done_busy, busy); end
  endtask

  task automatic test_correct();
    logic b; bit got;
    mem_zero(); mem[3] = 32'h00000100; clear_log(); max_delay = 0;
    do_start(b);
    wait_done(got);
    total++; if (!got || done_seen != 1) begin bad++; $display("FAIL corr_done: got=%0d pulses=%0d want 1", got, done_seen); end
    total++; if (n_writes != 1 || last_wr_addr !== 3'd3 || last_wr_data !== 32'h0) begin bad++; $display("FAIL corr_write: n=%0d addr=%0d data=%h want 1 3 0", n_writes, last_wr_addr, last_wr_data); end
    total++; if (corr_cnt !== 16'd1 || uncorr_cnt !== 16'd0 || err_flag !== 1'b0) begin bad++; $display("FAIL corr_cnt: corr=%0d uncorr=%0d flag=%b want 1 0 0", corr_cnt, uncorr_cnt, err_flag); end
  endtask

  task automatic test_uncorr();
    logic b; bit got; bit in_tab; logic [7:0] s; logic [31:0] one;
    s = mod_p(32'h00000300);
    in_tab = 0;
    one = 32'd1;
    for (int i = 0; i < 32; i++) if (mod_p(one << i) == s) in_tab = 1;
    total++; if (s !== 8'h2E || in_tab) begin bad++; $display("FAIL model_syndrome: s=%h in_table=%0d want 2e 0", s, in_tab); end
    mem_zero(); mem[5] = 32'h00000300; clear_log(); max_delay = 0;
    do_start(b);
    wait_done(got);
    total++; if (!got || done_seen != 1) begin bad++; $display("FAIL uncorr_done: got=%0d pulses=%0d want 1", got, done_seen); end
    total++; if (n_writes != 0 || mem[5] !== 32'h00000300) begin bad++; $display("FAIL uncorr_nowrite: n=%0d mem5=%h want 0 300", n_writes, mem[5]); end
    total++; if (uncorr_cnt !== 16'd1 || corr_cnt !== 16'd0) begin bad++; $display("FAIL uncorr_cnt: uncorr=%0d corr=%0d want 1 0", uncorr_cnt, corr_cnt); end
    total++; if (err_addr !== 3'd5 || err_flag !== 1'b1) begin bad++; $display("FAIL uncorr_err: addr=%0d flag=%b want 5 1", err_addr, err_flag); end
  endtask

  task automatic test_mixed(input int maxd);
    logic b; bit got;
    mem_zero();
    mem[1] = 32'h00000197;
    mem[3] = 32'h00000100;
    mem[5] = 32'h00000300;
    mem[6] = 32'h00000196;
    clear_log(); max_delay = maxd;
    do_start(b);
    wait_done(got);
    total++; if (!got || done_seen != 1 || n_reads != 8) begin bad++; $display("FAIL mixed%0d_done: got=%0d pulses=%0d reads=%0d want 1 1 8", maxd, got, done_seen, n_reads); end
    total++; if (n_writes != 2 || last_wr_addr !== 3'd6 || last_wr_data !== 32'h00000197) begin bad++; $display("FAIL mixed%0d_writes: n=%0d addr=%0d data=%h want 2 6 197", maxd, n_writes, last_wr_addr, last_wr_data); end
    total++; if (mem[1] !== 32'h197 || mem[3] !== 32'h0 || mem[5] !== 32'h300 || mem[6] !== 32'h197) begin bad++; $display("FAIL mixed%0d_mem: %h %h %h %h want 197 0 300 197", maxd, mem[1], mem[3], mem[5], mem[6]); end
    total++; if (corr_cnt !== 16'd2 || uncorr_cnt !== 16'd1) begin bad++; $display("FAIL mixed%0d_cnt: corr=%0d uncorr=%0d want 2 1", maxd, corr_cnt, uncorr_cnt); end
    total++; if (err_addr !== 3'd5 || err_flag !== 1'b1) begin bad++; $display("FAIL mixed%0d_err: addr=%0d flag=%b want 5 1", maxd, err_addr, err_flag); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL mixed%0d_stable: got %0d changes want 0", maxd, stab_err); end
    total++; if (done_busy != 0) begin bad++; $display("FAIL mixed%0d_done_busy: got %0d want 0", maxd, done_busy); end
  endtask

  task automatic test_abort();
    logic b; bit got; bit seen;
    mem_zero(); mem[2] = 32'h00000001; clear_log(); max_delay = 0;
    do_start(b);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK); #1;
      if (mem_req && mem_we) begin
        seen = 1;
        break;
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL abort_wr_seen: got 0 want 1"); end
    abort = 1'b1;
    wait_done(got);
    abort = 1'b0;
    total++; if (!got || done_seen != 1) begin bad++; $display("FAIL abort_done: got=%0d pulses=%0d want 1", got, done_seen); end
    total++; if (n_writes != 1 || last_wr_addr !== 3'd2 || last_wr_data !== 32'h0) begin bad++; $display("FAIL abort_write: n=%0d addr=%0d data=%h want 1 2 0", n_writes, last_wr_addr, last_wr_data); end
    total++; if (read_mask !== 8'b0000_0111 || n_reads != 3) begin bad++; $display("FAIL abort_reads: mask=%b n=%0d want 00000111 3", read_mask, n_reads); end
    total++; if (corr_cnt !== 16'd1 || uncorr_cnt !== 16'd0 || err_flag !== 1'b0) begin bad++; $display("FAIL abort_cnt: corr=%0d uncorr=%0d flag=%b want 1 0 0", corr_cnt, uncorr_cnt, err_flag); end
    total++; if (mem_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_idle: req=%b busy=%b want 0 0", mem_req, busy); end
  endtask

  task automatic test_reset_mid();
    logic b; bit got; bit seen;
    mem_zero(); mem[0] = 32'h00000196; clear_log(); max_delay = 5;
    do_start(b);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK); #1;
      if (mem_req && !mem_we && mem_addr == 3'd1) begin
        seen = 1;
        break;
      end
    end
    total++; if (!seen || corr_cnt !== 16'd1 || mem_wdata !== 32'h197) begin bad++; $display("FAIL midrst_pre: seen=%0d corr=%0d wdata=%h want 1 1 197", seen, corr_cnt, mem_wdata); end
    #1 reset = 1'b1;
    #1;
    total++; if ({busy, done, mem_req, mem_we} !== 4'b0000) begin bad++; $display("FAIL midrst_ctrl: got %b want 0000", {busy, done, mem_req, mem_we}); end
    total++; if (mem_addr !== 3'd0 || mem_wdata !== 32'h0 || corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0 || err_flag !== 1'b0) begin bad++; $display("FAIL midrst_regs: addr=%h wdata=%h corr=%0d uncorr=%0d flag=%b want 0", mem_addr, mem_wdata, corr_cnt, uncorr_cnt, err_flag); end
    @(posedge CLK); @(posedge CLK); #2 reset = 1'b0;
    mem_zero(); clear_log(); max_delay = 0;
    do_start(b);
    wait_done(got);
    total++; if (!got || done_seen != 1 || n_reads != 8 || first_rd !== 3'd0) begin bad++; $display("FAIL midrst_rescan: got=%0d pulses=%0d reads=%0d first=%0d want 1 1 8 0", got, done_seen, n_reads, first_rd); end
    total++; if (corr_cnt !== 16'd0 || n_writes != 0) begin bad++; $display("FAIL midrst_cnt: corr=%0d writes=%0d want 0 0", corr_cnt, n_writes); end
  endtask

  initial begin
    clear_log();
    mem_zero();
    test_reset();
    test_clean();
    test_correct();
    test_uncorr();
    test_mixed(0);
    test_mixed(7);
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
